obi_mem_responder: RTL and testbench

OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

---
 rtl/obi_mem_responder_pkg.sv | 14 +
 rtl/obi_rsp_pipe.sv | 34 +++
 rtl/obi_mem_responder.sv | 121 ++++++++++++
 tb/tb_obi_mem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_mem_responder_pkg.sv
// Shared OBI widths and grant FSM encoding for the memory responder.
package obi_mem_responder_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } gnt_state_e;

endpackage

// File: rtl/obi_rsp_pipe.sv
// Fixed-latency response delay line: valid and data shift together, cleared by reset.
module obi_rsp_pipe #(
    parameter int RSP_LATENCY = 1,
    parameter int DATA_W      = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [RSP_LATENCY-1:0] valid_q;
    logic [DATA_W-1:0]      data_q [RSP_LATENCY];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int k = 0; k < RSP_LATENCY; k++) data_q[k] <= '0;
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int k = 1; k < RSP_LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1];
                data_q[k]  <= data_q[k-1];
            end
        end
    end

    assign valid_o = valid_q[RSP_LATENCY-1];
    assign data_o  = data_q[RSP_LATENCY-1];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI memory responder: grant FSM with optional wait, byte-enabled RAM, fixed-latency in-order responses.
module obi_mem_responder
    import obi_mem_responder_pkg::*;
#(
    parameter int    MEM_WORDS   = 1024,
    parameter int    GNT_WAIT    = 0,
    parameter int    RSP_LATENCY = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output gnt_state_e        dbg_state_o
);

    localparam int         IDX_W   = $clog2(MEM_WORDS);
    localparam logic       NO_WAIT = (GNT_WAIT == 0);
    localparam logic       ONE_CYC = (GNT_WAIT <= 1);
    localparam logic [3:0] WAIT_M1 = 4'(GNT_WAIT - 1);

    gnt_state_e        state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;
    logic              unused_addr_bits;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // The IDLE cycle that sees req_i counts as the first wait cycle.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (ONE_CYC) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_WAIT;
                        wait_d  = 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (!req_i) begin
                    state_d = ST_IDLE;
                    wait_d  = '0;
                end else if (wait_q == WAIT_M1) begin
                    state_d = ST_READY;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_READY: begin
                if (req_i && !NO_WAIT) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign gnt_o = rst_ni && req_i
                   && ((state_q == ST_READY) || ((state_q == ST_IDLE) && NO_WAIT));
    assign accept      = gnt_o;
    assign dbg_state_o = state_q;

    assign idx              = addr_i[3 +: IDX_W];
    assign in_range         = (addr_i[ADDR_W-1:3+IDX_W] == '0);
    assign unused_addr_bits = ^addr_i[2:0];

    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            for (int k = 0; k < BE_W; k++) begin
                if (be_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    // Combinational read sees the pre-write word, giving read-before-write at the same edge.
    assign rd_word = (accept && !we_i && in_range) ? mem[idx] : '0;

    obi_rsp_pipe #(
        .RSP_LATENCY(RSP_LATENCY),
        .DATA_W     (DATA_W)
    ) u_rsp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .valid_i(accept),
        .data_i (rd_word),
        .valid_o(pipe_valid),
        .data_o (pipe_data)
    );

    assign rvalid_o = rst_ni && pipe_valid;
    assign rdata_o  = rvalid_o ? pipe_data : '0;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: default instance against a memory/queue model, plus a waited, long-latency instance.
module tb_obi_mem_responder;
    import obi_mem_responder_pkg::*;

    localparam int MW = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic rst_a, req_a, we_a, gnt_a, rvalid_a;
    logic [63:0] addr_a, wdata_a, rdata_a;
    logic [7:0] be_a;
    gnt_state_e st_a;

    logic rst_b, req_b, we_b, gnt_b, rvalid_b;
    logic [63:0] addr_b, wdata_b, rdata_b;
    logic [7:0] be_b;
    gnt_state_e st_b;

    obi_mem_responder dut_a (
        .clk_i(clk), .rst_ni(rst_a), .req_i(req_a), .gnt_o(gnt_a), .addr_i(addr_a),
        .we_i(we_a), .be_i(be_a), .wdata_i(wdata_a), .rvalid_o(rvalid_a),
        .rdata_o(rdata_a), .dbg_state_o(st_a)
    );

    obi_mem_responder #(.GNT_WAIT(3), .RSP_LATENCY(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_b), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr_b),
        .we_i(we_b), .be_i(be_b), .wdata_i(wdata_b), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .dbg_state_o(st_b)
    );

    // Reference model for the default instance: word array plus due-cycle scoreboard.
    logic [63:0] mem_a [MW];
    logic [63:0] exp_q [$];
    int          due_q [$];

    logic obs_gnt, obs_rvalid;
    logic [63:0] obs_rdata;
    gnt_state_e obs_state;
    logic exp_gnt, exp_rvalid;
    logic [63:0] exp_rdata;

    task automatic step_a(input logic rst, input logic req, input logic we,
                          input logic [63:0] addr, input logic [7:0] be, input logic [63:0] wd);
        logic [63:0] rd;
        int idx;
        rst_a = rst; req_a = req; we_a = we; addr_a = addr; be_a = be; wdata_a = wd;
        @(negedge clk);
        obs_gnt = gnt_a; obs_rvalid = rvalid_a; obs_rdata = rdata_a; obs_state = st_a;
        exp_gnt = rst && req;
        exp_rvalid = 1'b0;
        exp_rdata = 64'd0;
        if (rst && due_q.size() > 0 && due_q[0] == cyc) begin
            exp_rvalid = 1'b1;
            exp_rdata = exp_q.pop_front();
            void'(due_q.pop_front());
        end
        if (!rst) begin
            exp_q.delete();
            due_q.delete();
        end
        if (exp_gnt) begin
            rd = 64'd0;
            if (addr < 64'(8 * MW)) begin
                idx = int'(addr >> 3);
                if (!we) rd = mem_a[idx];
                else for (int k = 0; k < 8; k++) if (be[k]) mem_a[idx][8*k +: 8] = wd[8*k +: 8];
            end
            exp_q.push_back(rd);
            due_q.push_back(cyc + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic step_b(input logic rst, input logic req, input logic we,
                          input logic [63:0] addr, input logic [7:0] be, input logic [63:0] wd);
        rst_b = rst; req_b = req; we_b = we; addr_b = addr; be_b = be; wdata_b = wd;
        @(negedge clk);
        obs_gnt = gnt_b; obs_rvalid = rvalid_b; obs_rdata = rdata_b; obs_state = st_b;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            step_a(1'b0, 1'b1, 1'b0, 64'h40, 8'hFF, 64'd0);
            checks++; if (obs_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b want 0", obs_gnt); end
            checks++; if (obs_rvalid !== 1'b0 || obs_rdata !== 64'd0) begin
                errors++; $display("FAIL rst_rsp: got rvalid=%b rdata=%h want 0/0", obs_rvalid, obs_rdata); end
            checks++; if (obs_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", obs_state, ST_IDLE); end
        end
        step_a(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        checks++; if (obs_rvalid !== 1'b0) begin errors++; $display("FAIL rst_release_rvalid: got %b want 0", obs_rvalid); end
    endtask

    task automatic prefill;
        for (int i = 0; i < MW; i++) step_a(1'b1, 1'b1, 1'b1, 64'(i) * 8, 8'hFF, {$urandom, $urandom});
        step_a(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
    endtask

    task automatic test_write_read;
        step_a(1'b1, 1'b1, 1'b1, 64'h40, 8'hFF, 64'h1122334455667788);
        checks++; if (obs_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", obs_gnt); end
        step_a(1'b1, 1'b1, 1'b0, 64'h40, 8'h00, 64'd0);
        checks++; if (obs_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", obs_gnt); end
        checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== 64'd0) begin
            errors++; $display("FAIL wr_rsp: got rvalid=%b rdata=%h want 1/0", obs_rvalid, obs_rdata); end
        step_a(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== 64'h1122334455667788) begin
            errors++; $display("FAIL rd_rsp: got rvalid=%b rdata=%h want 1/1122334455667788", obs_rvalid, obs_rdata); end
        step_a(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        checks++; if (obs_rvalid !== 1'b0) begin errors++; $display("FAIL rsp_single_cycle: got %b want 0", obs_rvalid); end
    endtask

    task automatic test_partial;
        step_a(1'b1, 1'b1, 1'b1, 64'h40, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
        step_a(1'b1, 1'b1, 1'b0, 64'h44, 8'h00, 64'd0);
        step_a(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== 64'h11223344AAAAAAAA) begin
            errors++; $display("FAIL partial: got rvalid=%b rdata=%h want 1/11223344aaaaaaaa", obs_rvalid, obs_rdata); end
        step_a(1'b1, 1'b1, 1'b1, 64'h40, 8'h00, 64'hFFFFFFFFFFFFFFFF);
        step_a(1'b1, 1'b1, 1'b0, 64'h40, 8'h00, 64'd0);
        step_a(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        checks++; if (obs_rdata !== 64'h11223344AAAAAAAA) begin
            errors++; $display("FAIL be_zero: got %h want 11223344aaaaaaaa", obs_rdata); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 10; i++) begin
            step_a(1'b1, i < 8, 1'b0, 64'(i) * 8, 8'd0, 64'd0);
            checks++; if (obs_gnt !== (i < 8)) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b want %b", i, obs_gnt, i < 8); end
            if (i >= 1 && i <= 8) begin
                checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== exp_rdata) begin
                    errors++; $display("FAIL b2b_rsp[%0d]: got rvalid=%b rdata=%h want 1/%h", i, obs_rvalid, obs_rdata, exp_rdata); end
            end else begin
                checks++; if (obs_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d]: got %b want 0", i, obs_rvalid); end
            end
        end
    endtask

    task automatic test_out_of_range;
        logic [63:0] w0;
        w0 = mem_a[0];
        step_a(1'b1, 1'b1, 1'b1, 64'h2000, 8'hFF, 64'hDEADBEEFDEADBEEF);
        step_a(1'b1, 1'b1, 1'b0, 64'h2000, 8'h00, 64'd0);
        step_a(1'b1, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF8, 8'h00, 64'd0);
        checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== 64'd0) begin
            errors++; $display("FAIL oor_read: got rvalid=%b rdata=%h want 1/0", obs_rvalid, obs_rdata); end
        step_a(1'b1, 1'b1, 1'b0, 64'h0, 8'h00, 64'd0);
        checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== 64'd0) begin
            errors++; $display("FAIL oor_read_high: got rvalid=%b rdata=%h want 1/0", obs_rvalid, obs_rdata); end
        step_a(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        checks++; if (obs_rdata !== w0) begin errors++; $display("FAIL oor_no_alias: got %h want %h", obs_rdata, w0); end
    endtask

    task automatic test_random;
        logic req, we;
        logic [63:0] addr;
        for (int i = 0; i < 400; i++) begin
            req = ($urandom_range(0, 3) != 0);
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) addr = {$urandom, $urandom} | 64'h2000;
            else addr = 64'($urandom_range(0, MW - 1)) * 8 + 64'($urandom_range(0, 7));
            step_a(i != 200, req, we, addr, 8'($urandom_range(0, 255)), {$urandom, $urandom});
            checks++; if (obs_gnt !== exp_gnt || obs_rvalid !== exp_rvalid || obs_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL rand[%0d]: got gnt=%b rvalid=%b rdata=%h want %b/%b/%h",
                         i, obs_gnt, obs_rvalid, obs_rdata, exp_gnt, exp_rvalid, exp_rdata);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step_a(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
            checks++; if (obs_rvalid !== exp_rvalid || obs_rdata !== exp_rdata) begin
                errors++; $display("FAIL rand_drain[%0d]: got %b/%h want %b/%h", i, obs_rvalid, obs_rdata, exp_rvalid, exp_rdata); end
        end
    endtask

    task automatic test_gnt_wait(input logic [63:0] val);
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 12; i++) begin
                step_b(1'b1, i <= 3, t == 0, 64'h80, 8'hFF, val);
                checks++; if (obs_gnt !== (i == 3)) begin errors++; $display("FAIL wait_gnt[%0d][%0d]: got %b want %b", t, i, obs_gnt, i == 3); end
                checks++; if (obs_rvalid !== (i == 7)) begin errors++; $display("FAIL wait_rvalid[%0d][%0d]: got %b want %b", t, i, obs_rvalid, i == 7); end
                if (i == 1) begin
                    checks++; if (obs_state !== ST_WAIT) begin errors++; $display("FAIL wait_state: got %0d want %0d", obs_state, ST_WAIT); end
                end
                if (i == 7) begin
                    checks++; if (obs_rdata !== ((t == 0) ? 64'd0 : val)) begin
                        errors++; $display("FAIL wait_rdata[%0d]: got %h want %h", t, obs_rdata, (t == 0) ? 64'd0 : val); end
                end
            end
        end
    endtask

    task automatic test_wait_abort(input logic [63:0] val);
        for (int i = 0; i < 12; i++) begin
            step_b(1'b1, (i < 2) || (i >= 3 && i <= 6), 1'b0, 64'h80, 8'h00, 64'd0);
            checks++; if (obs_gnt !== (i == 6)) begin errors++; $display("FAIL abort_gnt[%0d]: got %b want %b", i, obs_gnt, i == 6); end
            if (i == 3) begin
                checks++; if (obs_state !== ST_IDLE) begin errors++; $display("FAIL abort_state: got %0d want %0d", obs_state, ST_IDLE); end
            end
            if (i == 10) begin
                checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== val) begin
                    errors++; $display("FAIL abort_rsp: got %b/%h want 1/%h", obs_rvalid, obs_rdata, val); end
            end
        end
    endtask

    task automatic test_reset_mid(input logic [63:0] val);
        for (int i = 0; i < 14; i++) begin
            step_b(i != 5, i <= 3, 1'b0, 64'h80, 8'h00, 64'd0);
            checks++; if (obs_rvalid !== 1'b0) begin errors++; $display("FAIL drop_inflight[%0d]: got %b want 0", i, obs_rvalid); end
        end
        for (int i = 0; i < 9; i++) begin
            step_b(1'b1, i <= 3, 1'b0, 64'h80, 8'h00, 64'd0);
            checks++; if (obs_gnt !== (i == 3)) begin errors++; $display("FAIL post_rst_gnt[%0d]: got %b want %b", i, obs_gnt, i == 3); end
            checks++; if (obs_rvalid !== (i == 7) || (i == 7 && obs_rdata !== val)) begin
                errors++; $display("FAIL post_rst_rsp[%0d]: got %b/%h want %b/%h", i, obs_rvalid, obs_rdata, i == 7, val); end
        end
    endtask

    initial begin
        logic [63:0] val;
        rst_b = 1'b0; req_b = 1'b0; we_b = 1'b0; addr_b = '0; be_b = '0; wdata_b = '0;
        test_reset;
        prefill;
        test_write_read;
        test_partial;
        test_back_to_back;
        test_out_of_range;
        test_random;
        req_a = 1'b0;
        step_b(1'b0, 1'b1, 1'b0, 64'd0, 8'd0, 64'd0);
        checks++; if (obs_gnt !== 1'b0 || obs_rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_b: got gnt=%b rvalid=%b want 0/0", obs_gnt, obs_rvalid); end
        step_b(1'b1, 1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        val = {$urandom, $urandom};
        test_gnt_wait(val);
        test_wait_abort(val);
        test_reset_mid(val);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
